// File: rtl/mips_dbg_pkg.sv
// Shared debug-control types for the MIPS core: command ops,
// run states and default counter widths.
package mips_dbg_pkg;

  typedef enum logic [1:0] {
    OP_HALT   = 2'd0,
    OP_RUN    = 2'd1,
    OP_STEP   = 2'd2,
    OP_SET_BP = 2'd3
  } cmd_op_e;

  typedef enum logic [1:0] {
    ST_HALTED = 2'd0,
    ST_RUN    = 2'd1,
    ST_STEP   = 2'd2
  } run_st_e;

  localparam int CNT_W_DEF  = 32;
  localparam int STEP_W_DEF = 16;

endpackage

// File: rtl/mips_run_ctrl_if.sv
// Debug command channel: valid/ready handshake carrying op and argument.
// The host drives through master, the run controller receives on slave.
interface mips_run_ctrl_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [31:0] cmd_arg;

  modport master (
    output cmd_valid,
    output cmd_op,
    output cmd_arg,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_op,
    input  cmd_arg,
    output cmd_ready
  );
endinterface

// File: rtl/mips_run_ctrl.sv
// Run/halt/single-step clock-enable controller for the MIPS core.
// Define RUN_CTRL_BP_EN to build the PC breakpoint logic.
module mips_run_ctrl
  import mips_dbg_pkg::*;
#(
  parameter int CNT_W  = CNT_W_DEF,
  parameter int STEP_W = STEP_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  mips_run_ctrl_if.slave   cmd,
  input  logic [31:0]      pc_current,
  output logic             cpu_en,
  output logic             halted,
  output logic             bp_hit,
  output logic [CNT_W-1:0] retired
);

  run_st_e           state;
  cmd_op_e           op;
  logic [STEP_W-1:0] remaining;
  logic [STEP_W-1:0] step_cnt;
  logic              running;
  logic              acc;
  logic              acc_halt;
  logic              acc_run;
  logic              acc_step;
  logic              acc_bp;
  logic              bp_stop;
  logic              last_step;

  assign op       = cmd_op_e'(cmd.cmd_op);
  assign halted   = (state == ST_HALTED);
  assign running  = ~halted;

  assign cmd.cmd_ready = halted
                       | (op == OP_HALT)
                       | (op == OP_SET_BP);

  assign acc      = cmd.cmd_valid & cmd.cmd_ready;
  assign acc_halt = acc & (op == OP_HALT);
  assign acc_run  = acc & (op == OP_RUN);
  assign acc_step = acc & (op == OP_STEP);
  assign acc_bp   = acc & (op == OP_SET_BP);

  assign step_cnt = cmd.cmd_arg[STEP_W-1:0];

  assign cpu_en    = running & ~bp_stop;
  assign last_step = (state == ST_STEP) & cpu_en
                   & (remaining == STEP_W'(1));

`ifdef RUN_CTRL_BP_EN
  logic        bp_valid;
  logic [31:0] bp_addr;
  logic        bp_mask;
  logic        hit_q;

  // Compare is gated by running so a halted core parked on
  // the breakpoint can still accept RUN/STEP.
  assign bp_stop = running & bp_valid & ~bp_mask
                 & (pc_current == bp_addr);
  assign bp_hit  = hit_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bp_valid <= 1'b0;
      bp_addr  <= '0;
      bp_mask  <= 1'b0;
      hit_q    <= 1'b0;
    end else begin
      if (acc_bp) begin
        bp_valid <= 1'b1;
        bp_addr  <= cmd.cmd_arg;
      end
      if (acc_run | acc_step) begin
        bp_mask <= 1'b1;
      end else if (running) begin
        bp_mask <= 1'b0;
      end
      if (bp_stop) begin
        hit_q <= 1'b1;
      end else if (acc_run | acc_step) begin
        hit_q <= 1'b0;
      end
    end
  end
`else
  logic unused_bp;

  assign bp_stop   = 1'b0;
  assign bp_hit    = 1'b0;
  assign unused_bp = acc_bp
                   ^ (^cmd.cmd_arg[31:STEP_W])
                   ^ (^pc_current);
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_HALTED;
      remaining <= '0;
    end else begin
      if ((state == ST_STEP) && cpu_en) begin
        remaining <= remaining - STEP_W'(1);
      end
      if (last_step || bp_stop) begin
        state <= ST_HALTED;
      end
      unique case (1'b1)
        acc_halt: state <= ST_HALTED;
        acc_run:  state <= ST_RUN;
        acc_step: begin
          state     <= ST_STEP;
          remaining <= (step_cnt == '0) ? STEP_W'(1)
                                        : step_cnt;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      retired <= '0;
    end else if (cpu_en) begin
      retired <= retired + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_mips_run_ctrl.sv
// Randomized and directed bench for mips_run_ctrl against
// a behavioural model of the run/step/breakpoint rules.
module tb_mips_run_ctrl;

`ifdef RUN_CTRL_BP_EN
  localparam bit BP_EN = 1'b1;
`else
  localparam bit BP_EN = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic [31:0] pc_current;
  logic        cpu_en;
  logic        halted;
  logic        bp_hit;
  logic [31:0] retired;

  mips_run_ctrl_if cif ();

  mips_run_ctrl #(.CNT_W(32), .STEP_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd        (cif.slave),
    .pc_current (pc_current),
    .cpu_en     (cpu_en),
    .halted     (halted),
    .bp_hit     (bp_hit),
    .retired    (retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total;
  int passed;

  // model: mode 0=halted 1=free run 2=stepping
  int          m_mode;
  int          m_left;
  bit          m_fresh;
  bit          m_bpv;
  logic [31:0] m_bpa;
  bit          m_hit;
  logic [31:0] m_ret;

  logic [31:0] pc;
  bit          ramp;
  int          n_en;
  bit          s_en;
  bit          s_ready;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  task automatic model_reset();
    m_mode  = 0;
    m_left  = 0;
    m_fresh = 0;
    m_bpv   = 0;
    m_bpa   = '0;
    m_hit   = 0;
    m_ret   = '0;
  endtask

  task automatic cyc(input bit v, input logic [1:0] op,
                     input logic [31:0] arg);
    bit stop, en, rdy, acc;
    int nxt;
    cif.cmd_valid = v;
    cif.cmd_op    = op;
    cif.cmd_arg   = arg;
    pc_current    = pc;
    #1;
    stop = BP_EN && m_mode != 0 && m_bpv
           && pc == m_bpa && !m_fresh;
    en   = m_mode != 0 && !stop;
    rdy  = m_mode == 0 || op == 2'd0 || op == 2'd3;
    chk("cmd_ready", cif.cmd_ready, rdy);
    chk("cpu_en", cpu_en, en);
    chk("halted", halted, m_mode == 0);
    chk("bp_hit", bp_hit, m_hit);
    chk("retired", retired, m_ret);
    s_en    = cpu_en;
    s_ready = cif.cmd_ready;
    acc     = v && rdy;
    @(posedge clk);
    nxt = m_mode;
    if (en) begin
      m_ret = m_ret + 1;
      n_en++;
    end
    if (m_mode == 2 && en) begin
      if (m_left == 1) nxt = 0;
      m_left--;
    end
    if (stop) begin
      nxt   = 0;
      m_hit = 1;
    end
    if (m_mode != 0) m_fresh = 0;
    if (acc) begin
      case (op)
        2'd0: nxt = 0;
        2'd1: begin
          nxt = 1; m_hit = 0; m_fresh = 1;
        end
        2'd2: begin
          nxt = 2; m_hit = 0; m_fresh = 1;
          m_left = (arg[15:0] == 0) ? 1 : int'(arg[15:0]);
        end
        default: if (BP_EN) begin
          m_bpv = 1; m_bpa = arg;
        end
      endcase
    end
    m_mode = nxt;
    if (ramp && en) begin
      pc = pc + 32'h4;
      if (pc >= 32'h80) pc = '0;
    end
    @(negedge clk);
  endtask

  task automatic pulse_reset();
    #2 rst = 1'b0;
    #1;
    model_reset();
    chk("rst_cpu_en", cpu_en, 1'b0);
    chk("rst_halted", halted, 1'b1);
    chk("rst_retired", retired, 32'd0);
    chk("rst_bp_hit", bp_hit, 1'b0);
    chk("rst_ready", cif.cmd_ready, 1'b1);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    int c0;
    bit got;
    bit en20;
    logic [31:0] p;
    logic [1:0]  rop;
    logic [31:0] rarg;
    int r;
    total = 0; passed = 0; n_en = 0;
    pc = 32'h100; ramp = 0;
    rst = 1'b0;
    cif.cmd_valid = 0; cif.cmd_op = '0; cif.cmd_arg = '0;
    pc_current = pc;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    chk("init_halted", halted, 1'b1);
    chk("init_cpu_en", cpu_en, 1'b0);
    chk("init_ready", cif.cmd_ready, 1'b1);
    rst = 1'b1;
    @(negedge clk);

    // STEP 3 then STEP 0
    c0 = n_en;
    cyc(1, 2'd2, 32'd3);
    repeat (5) cyc(0, 2'd0, 0);
    chk("step3_cycles", n_en - c0, 3);
    chk("step3_retired", retired, 32'd3);
    c0 = n_en;
    cyc(1, 2'd2, 32'd0);
    repeat (4) cyc(0, 2'd0, 0);
    chk("step0_cycles", n_en - c0, 1);
    chk("step0_retired", retired, 32'd4);

    // back-pressure while running
    cyc(1, 2'd1, 0);
    cyc(1, 2'd2, 32'd5);
    chk("bp_step_ready", s_ready, 1'b0);
    cyc(1, 2'd0, 0);
    chk("halt_ready", s_ready, 1'b1);
    cyc(0, 2'd0, 0);
    chk("halt_en_off", s_en, 1'b0);

    // reset mid-run
    cyc(1, 2'd1, 0);
    repeat (5) cyc(0, 2'd0, 0);
    pulse_reset();
    c0 = n_en;
    repeat (3) cyc(0, 2'd0, 0);
    chk("post_rst_idle", n_en - c0, 0);

    // breakpoint with ramping PC
    pc = 0; ramp = 1; got = 0; en20 = 0;
    cyc(1, 2'd3, 32'h20);
    cyc(1, 2'd1, 0);
    for (int i = 0; i < 20; i++) begin
      p = pc;
      cyc(0, 2'd0, 0);
      if (p == 32'h20 && !got) begin
        got = 1; en20 = s_en;
      end
    end
    chk("bp_reached", got, 1'b1);
    chk("bp_en_at_20", en20, !BP_EN);
    chk("bp_halted", halted, BP_EN);
    chk("bp_hit_set", bp_hit, BP_EN);
    cyc(1, 2'd0, 0);

    // resume from the breakpoint PC
    ramp = 0; pc = 32'h20;
    cyc(1, 2'd1, 0);
    cyc(0, 2'd0, 0);
    chk("resume_en", s_en, 1'b1);
    chk("resume_hit_clr", bp_hit, 1'b0);
    cyc(0, 2'd0, 0);
    cyc(1, 2'd0, 0);
    c0 = n_en;
    cyc(1, 2'd2, 32'd1);
    repeat (4) cyc(0, 2'd0, 0);
    chk("resume_step1", n_en - c0, 1);

    // HALT in the final step cycle
    pc = 32'h100;
    c0 = n_en;
    cyc(1, 2'd2, 32'd2);
    cyc(0, 2'd0, 0);
    cyc(1, 2'd0, 0);
    repeat (3) cyc(0, 2'd0, 0);
    chk("sim_halt_cycles", n_en - c0, 2);
    chk("sim_halt_halted", halted, 1'b1);

    // randomized traffic
    ramp = 1; pc = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 399) == 0) pulse_reset();
      r = $urandom_range(0, 9);
      if (r == 0) rop = 2'd0;
      else if (r < 4) rop = 2'd1;
      else if (r < 7) rop = 2'd2;
      else rop = 2'd3;
      if (rop == 2'd2) rarg = $urandom_range(0, 6);
      else if (rop == 2'd3) rarg = {$urandom_range(0, 31), 2'b00};
      else rarg = $urandom;
      cyc($urandom_range(0, 1) == 1, rop, rarg);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
